rot_register_file_seq: RTL

- Parametrised successor of the nibble-serial rotating register file.
- Holds NUM_REGS words of NIBBLES×DATA_BITS bits; every register rotates by one nibble per clock in lockstep with the shared nibble counter.
- Adds a sequenced whole-word write port (request, alignment wait, busy/done), an optional hardwired-zero register 0, and a configurable number of nibbles per word.
- Sits between the CPU/VGA sequencer and the datapath; read ports deliver nibble `counter` of the addressed register each cycle.

---
 rtl/rot_register_file_seq.sv | 122 ++++++++++++
 1 files changed

// File: rtl/rot_register_file_seq.sv
// Nibble-serial rotating register file with a sequenced whole-word write port.
// Every word rotates one nibble per clock; the bottom nibble always has index == counter.
module rot_register_file_seq #(
    parameter int unsigned NUM_REGS  = 16,
    parameter int unsigned ADDR_BITS = 4,
    parameter int unsigned DATA_BITS = 4,
    parameter int unsigned NIBBLES   = 8,
    parameter int unsigned CNT_BITS  = 3,
    parameter int unsigned ZERO_REG  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CNT_BITS-1:0]  counter,
    input  logic [ADDR_BITS-1:0] r1_addr,
    input  logic [ADDR_BITS-1:0] r2_addr,
    input  logic                 w_req,
    input  logic [ADDR_BITS-1:0] w_addr,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 w_busy,
    output logic                 w_done,
    output logic [DATA_BITS-1:0] data_out1,
    output logic [DATA_BITS-1:0] data_out2
);

    localparam int unsigned WORD_BITS = NIBBLES * DATA_BITS;
    localparam logic [CNT_BITS-1:0] FIRST_NIB = CNT_BITS'(0);
    localparam logic [CNT_BITS-1:0] LAST_NIB  = CNT_BITS'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t                 state;
    logic [ADDR_BITS-1:0]   addr_q;
    logic                   store_en_c;
    logic [ADDR_BITS-1:0]   store_addr_c;
    logic [DATA_BITS-1:0]   bottom [NUM_REGS];

    // Write sequencer; w_busy follows "write pending or accepted" one cycle late.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            addr_q <= '0;
            w_busy <= 1'b0;
            w_done <= 1'b0;
        end else begin
            w_done <= 1'b0;
            case (state)
                IDLE: begin
                    w_busy <= w_req;
                    if (w_req) begin
                        addr_q <= w_addr;
                        state  <= (counter == FIRST_NIB) ? WRITE : ALIGN;
                    end
                end
                ALIGN: begin
                    w_busy <= 1'b1;
                    if (counter == FIRST_NIB) begin
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    w_busy <= 1'b1;
                    if (counter == LAST_NIB) begin
                        state  <= IDLE;
                        w_done <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    w_busy <= 1'b0;
                end
            endcase
        end
    end

    // Nibble store strobe; an acceptance at counter 0 stores immediately using w_addr.
    always_comb begin
        store_en_c   = 1'b0;
        store_addr_c = addr_q;
        case (state)
            IDLE: begin
                if (w_req && (counter == FIRST_NIB)) begin
                    store_en_c   = 1'b1;
                    store_addr_c = w_addr;
                end
            end
            ALIGN:   store_en_c = (counter == FIRST_NIB);
            WRITE:   store_en_c = 1'b1;
            default: store_en_c = 1'b0;
        endcase
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
            assign bottom[i] = '0;
        end else begin : g_word
            logic [WORD_BITS-1:0] word;
            logic [DATA_BITS-1:0] top_c;

            // The re-entering nibble is replaced on a store, so nothing else shifts.
            assign top_c = (store_en_c && (store_addr_c == ADDR_BITS'(i)))
                         ? data_in : word[DATA_BITS-1:0];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    word <= '0;
                end else begin
                    word <= {top_c, word[WORD_BITS-1:DATA_BITS]};
                end
            end

            assign bottom[i] = word[DATA_BITS-1:0];
        end
    end

    assign data_out1 = bottom[r1_addr];
    assign data_out2 = bottom[r2_addr];

endmodule
